// File: rtl/csr_serializer.sv
// CSR serialization at rename/dispatch: a CSR op is held until it has been the ROB head
// for DRAIN_DELAY cycles, and all dispatch is held while it is in flight until it retires.
module csr_serializer #(
    parameter int ROBID_W     = 7,
    parameter int DRAIN_DELAY = 2,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rename_csr_valid,
    input  logic [ROBID_W-1:0] rename_robid,
    input  logic               rename_dispatch,
    input  logic [ROBID_W-1:0] rob_head_robid,
    input  logic               rob_retire,
    input  logic [ROBID_W-1:0] rob_retire_robid,
    input  logic               rob_flush,
    output logic               csr_entry_stall,
    output logic               csr_exit_stall,
    output logic               csr_busy,
    output logic [ROBID_W-1:0] csr_robid
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] ISSUED = 2'd2;

    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_DELAY);

    logic [1:0]         state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [ROBID_W-1:0] robid_q, robid_next;
    logic               head_ok;
    logic               ready;

    assign head_ok = (rob_head_robid == rename_robid);
    assign ready   = (state == DRAIN) && head_ok && (cnt == '0);

    // Outputs depend only on state/cnt and non-dispatch inputs, so rename_stall cannot loop.
    always_comb begin
        csr_entry_stall = 1'b0;
        csr_exit_stall  = 1'b0;
        case (state)
            IDLE:    csr_entry_stall = rename_csr_valid;
            DRAIN:   csr_entry_stall = ~ready;
            ISSUED: begin
                csr_entry_stall = rename_csr_valid;
                csr_exit_stall  = 1'b1;
            end
            default: csr_entry_stall = rename_csr_valid;
        endcase
    end

    assign csr_busy  = (state != IDLE);
    assign csr_robid = robid_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        robid_next = robid_q;
        if (rob_flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rename_csr_valid) begin
                        state_next = DRAIN;
                        cnt_next   = DRAIN_INIT;
                    end
                end
                DRAIN: begin
                    if (!rename_csr_valid) begin
                        state_next = IDLE;
                    end else if (ready && rename_dispatch) begin
                        state_next = ISSUED;
                        robid_next = rename_robid;
                    end else if (!head_ok) begin
                        cnt_next = DRAIN_INIT;
                    end else if (cnt != '0) begin
                        cnt_next = cnt - 1'b1;
                    end
                end
                // A CSR arriving alongside the retire is picked up from IDLE next cycle.
                ISSUED: begin
                    if (rob_retire && (rob_retire_robid == robid_q)) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            robid_q <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            robid_q <= robid_next;
        end
    end

endmodule

// File: tb/tb_csr_serializer.sv
// Testbench for csr_serializer: directed scenarios followed by random traffic, checked
// against a reference model that tracks head-streak length instead of a down-counter.
module tb_csr_serializer;

    localparam int ROBID_W = 7;
    localparam int D       = 2;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               rename_csr_valid;
    logic [ROBID_W-1:0] rename_robid;
    logic               rename_dispatch;
    logic [ROBID_W-1:0] rob_head_robid;
    logic               rob_retire;
    logic [ROBID_W-1:0] rob_retire_robid;
    logic               rob_flush;
    logic               csr_entry_stall;
    logic               csr_exit_stall;
    logic               csr_busy;
    logic [ROBID_W-1:0] csr_robid;

    int errors = 0;
    int checks = 0;

    // Reference model: waiting for release, in flight, tag of in-flight op, consecutive head cycles
    bit                 m_waiting;
    bit                 m_inflight;
    logic [ROBID_W-1:0] m_tag;
    int                 m_streak;

    always #5 clk = ~clk;

    csr_serializer #(.ROBID_W(ROBID_W), .DRAIN_DELAY(D), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .rename_csr_valid (rename_csr_valid),
        .rename_robid     (rename_robid),
        .rename_dispatch  (rename_dispatch),
        .rob_head_robid   (rob_head_robid),
        .rob_retire       (rob_retire),
        .rob_retire_robid (rob_retire_robid),
        .rob_flush        (rob_flush),
        .csr_entry_stall  (csr_entry_stall),
        .csr_exit_stall   (csr_exit_stall),
        .csr_busy         (csr_busy),
        .csr_robid        (csr_robid)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs (dispatch follows the expected stalls), checks, then advances the model.
    task automatic applyStimulus(input bit valid, input logic [ROBID_W-1:0] robid,
                                 input logic [ROBID_W-1:0] head, input bit disp_en,
                                 input bit retire, input logic [ROBID_W-1:0] rrobid,
                                 input bit flush, input bit rst_v);
        bit head_ok, ready, exp_entry, exp_exit, disp;
        rename_csr_valid = valid;
        rename_robid     = robid;
        rob_head_robid   = head;
        rob_retire       = retire;
        rob_retire_robid = rrobid;
        rob_flush        = flush;
        rst              = rst_v;
        head_ok   = (head == robid);
        ready     = m_waiting && head_ok && (m_streak >= D);
        exp_exit  = m_inflight;
        exp_entry = m_waiting ? !ready : valid;
        disp      = valid && disp_en && !exp_entry && !exp_exit;
        rename_dispatch = disp;
        #1;
        checkOutput("entry_stall", 32'(csr_entry_stall), 32'(exp_entry));
        checkOutput("exit_stall",  32'(csr_exit_stall),  32'(exp_exit));
        checkOutput("busy",        32'(csr_busy),        32'(m_waiting || m_inflight));
        checkOutput("robid",       32'(csr_robid),       32'(m_tag));
        @(posedge clk);
        if (rst_v) begin
            m_waiting = 0; m_inflight = 0; m_tag = '0; m_streak = 0;
        end else if (flush) begin
            m_waiting = 0; m_inflight = 0; m_streak = 0;
        end else if (m_inflight) begin
            if (retire && rrobid == m_tag) m_inflight = 0;
        end else if (m_waiting) begin
            if (!valid) begin
                m_waiting = 0;
            end else if (ready && disp) begin
                m_waiting = 0; m_inflight = 1; m_tag = robid;
            end else if (head_ok) begin
                if (m_streak < 1000) m_streak++;
            end else begin
                m_streak = 0;
            end
        end else if (valid) begin
            m_waiting = 1; m_streak = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [ROBID_W-1:0] r_robid;
        rst = 1; rename_csr_valid = 0; rename_robid = '0; rename_dispatch = 0;
        rob_head_robid = '0; rob_retire = 0; rob_retire_robid = '0; rob_flush = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_waiting = 0; m_inflight = 0; m_tag = '0; m_streak = 0;
        $display("[TB] reset released");

        // CSR 5 already at head: released on its fourth cycle, then in flight until retire
        for (int i = 0; i < 5; i++) applyStimulus(1, 5, 5, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 5, 0, 1, 5, 0, 0);
        applyStimulus(0, 0, 6, 0, 0, 0, 0, 0);

        // CSR 9 behind head 7, then a head change mid-drain restarts the count
        for (int i = 0; i < 4; i++) applyStimulus(1, 9, 7, 1, 0, 0, 0, 0);
        applyStimulus(1, 9, 9, 1, 0, 0, 0, 0);
        applyStimulus(1, 9, 7, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 9, 9, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 9, 0, 1, 8, 0, 0);
        applyStimulus(0, 0, 9, 0, 1, 9, 0, 0);
        applyStimulus(0, 0, 10, 0, 0, 0, 0, 0);

        // Flush while draining with one cycle left, then flush while issued
        for (int i = 0; i < 2; i++) applyStimulus(1, 2, 2, 0, 0, 0, 0, 0);
        applyStimulus(1, 2, 2, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 2, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 2, 2, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 2, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 2, 0, 0, 0, 0, 0);

        // Back-to-back CSRs 3 and 4
        for (int i = 0; i < 4; i++) applyStimulus(1, 3, 3, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 4, 3, 1, 0, 0, 0, 0);
        applyStimulus(1, 4, 4, 1, 1, 3, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 4, 4, 1, 0, 0, 0, 0);

        // Reset while issued with a matching retire
        applyStimulus(0, 0, 4, 0, 1, 4, 0, 1);
        applyStimulus(0, 0, 4, 0, 0, 0, 0, 0);

        // Random traffic with small tags so heads and retires match often
        r_robid = 7'd1;
        for (int i = 0; i < 400; i++) begin
            logic [ROBID_W-1:0] head, rrob;
            if (!m_waiting && ($urandom % 4 == 0))
                r_robid = ($urandom % 8 == 0) ? 7'd127 : 7'($urandom_range(0, 5));
            head = ($urandom % 3 != 0) ? r_robid : 7'($urandom_range(0, 5));
            rrob = ($urandom % 2 == 0) ? m_tag : 7'($urandom_range(0, 5));
            applyStimulus($urandom % 10 != 0, r_robid, head, $urandom % 4 != 0,
                          $urandom % 3 == 0, rrob, $urandom % 30 == 0, $urandom % 100 == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
